bpu_bht_btb: RTL and testbench

//  Dynamic branch predictor for the 5-stage pipeline; replaces static predict-not-taken.
//  IF-stage lookup: direct-mapped BTB plus per-entry saturating counters give next-PC guess.

---
 rtl/bpu_bht_btb.sv | 127 ++++++++++++
 tb/tb_bpu_bht_btb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_bht_btb.sv
// Dynamic branch predictor: direct-mapped BTB with a saturating direction
// counter per entry. Lookup is combinational from if_pc. Training happens on
// the clock edge from the EX-stage resolution. Two saturating performance
// counters record updates and mispredicts.
//
// Handshake: there is no backpressure. upd_valid=1 marks upd_pc, upd_uncond,
// upd_taken, upd_target and upd_mispred as meaningful for exactly this cycle.
// The update is consumed on the next rising edge. While upd_valid=0 the upd_*
// inputs are ignored, even if they are X.
module bpu_bht_btb #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_uncond,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispred,
    input  logic              bpu_flush,
    output logic [PERF_W-1:0] perf_upd,
    output logic [PERF_W-1:0] perf_mis
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_WEAK_N = {1'b0, {(CNT_W-1){1'b1}}};

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];

    logic [PERF_W-1:0] perf_upd_q;
    logic [PERF_W-1:0] perf_mis_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [CNT_W-1:0]  up_cnt_cur;
    logic [CNT_W-1:0]  up_cnt_next;

    // PC bits that take no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[ADDR_W-1:IDX_W+TAG_W+2],
                              upd_pc[1:0], upd_pc[ADDR_W-1:IDX_W+TAG_W+2]};

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // IF-stage lookup. It reads the registered table only, so a same-cycle
    // update is not bypassed and the lookup sees the old contents.
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[lk_idx] : (if_pc + ADDR_W'(4));
    end

    // Counter training for an update that hits its entry.
    always_comb begin
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_cnt_cur  = cnt_q[up_idx];
        up_cnt_next = up_cnt_cur;
        if (upd_uncond) begin
            up_cnt_next = CNT_MAX;
        end else if (upd_taken) begin
            if (up_cnt_cur != CNT_MAX) up_cnt_next = up_cnt_cur + CNT_W'(1);
        end else begin
            if (up_cnt_cur != '0) up_cnt_next = up_cnt_cur - CNT_W'(1);
        end
    end

    // Table state: reset, flush (valid bits only), then train or allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= CNT_WEAK_N;
                tgt_q[i]   <= '0;
            end
        end else if (bpu_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                cnt_q[up_idx] <= up_cnt_next;
                if (upd_taken) tgt_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                cnt_q[up_idx]   <= upd_uncond ? CNT_MAX : CNT_WEAK_T;
            end
        end
    end

    // Performance counters. They saturate at all-ones and ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else if (upd_valid) begin
            if (perf_upd_q != '1) perf_upd_q <= perf_upd_q + PERF_W'(1);
            if (upd_mispred && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + PERF_W'(1);
        end
    end

    assign perf_upd = perf_upd_q;
    assign perf_mis = perf_mis_q;

endmodule

// File: tb/tb_bpu_bht_btb.sv
// Testbench for bpu_bht_btb. Directed scenarios are followed by random
// traffic, and every result is compared against an entry-level reference
// model of the predictor.
module tb_bpu_bht_btb;

    localparam int AW = 32;
    localparam int NE = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] if_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_uncond;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_mispred;
    logic          bpu_flush;
    logic [31:0]   perf_upd;
    logic [31:0]   perf_mis;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    bpu_bht_btb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_pc       (if_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_uncond  (upd_uncond),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_mispred (upd_mispred),
        .bpu_flush   (bpu_flush),
        .perf_upd    (perf_upd),
        .perf_mis    (perf_mis)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // reference model: one record per BTB slot, counter held as an integer
    bit            m_v   [NE];
    int            m_tag [NE];
    int            m_cnt [NE];
    logic [AW-1:0] m_tgt [NE];
    longint        m_pu;
    longint        m_pm;
    localparam longint PERF_MAX = 64'd4294967295;

    function automatic int idx_of(input logic [AW-1:0] pc);
        return int'((pc / 4) % NE);
    endfunction

    function automatic int tag_of(input logic [AW-1:0] pc);
        return int'((pc / (4 * NE)) % 256);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NE; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = '0;
        end
        m_pu = 0;
        m_pm = 0;
    endtask

    function automatic logic [33:0] m_lookup(input logic [AW-1:0] pc);
        int  i = idx_of(pc);
        bit  h = m_v[i] && (m_tag[i] == tag_of(pc));
        bit  t = h && (m_cnt[i] >= 2);
        logic [AW-1:0] nxt = pc + 32'd4;
        return {h, t, (t ? m_tgt[i] : nxt)};
    endfunction

    task automatic m_update(input bit uv, input logic [AW-1:0] upc, input bit unc,
                            input bit ut, input logic [AW-1:0] utgt, input bit umis,
                            input bit fl);
        int i;
        int t;
        if (uv) begin
            if (m_pu < PERF_MAX) m_pu++;
            if (umis && m_pm < PERF_MAX) m_pm++;
        end
        if (fl) begin
            for (int k = 0; k < NE; k++) m_v[k] = 0;
        end else if (uv) begin
            i = idx_of(upc);
            t = tag_of(upc);
            if (m_v[i] && m_tag[i] == t) begin
                if (unc)     m_cnt[i] = 3;
                else if (ut) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                else         m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                if (ut) m_tgt[i] = utgt;
            end else if (ut) begin
                m_v[i] = 1; m_tag[i] = t; m_tgt[i] = utgt;
                m_cnt[i] = unc ? 3 : 2;
            end
        end
    endtask

    // scoreboard of expected {hit, taken, target}
    logic [33:0] exp_q[$];

    // driver: one full cycle with lookup check mid-cycle and perf check after the edge
    task automatic cycle(input logic [AW-1:0] ipc, input bit uv, input logic [AW-1:0] upc,
                         input bit unc, input bit ut, input logic [AW-1:0] utgt,
                         input bit umis, input bit fl);
        logic [33:0] e;
        if_pc     = ipc;
        upd_valid = uv;
        bpu_flush = fl;
        if (uv) begin
            upd_pc = upc; upd_uncond = unc; upd_taken = ut;
            upd_target = utgt; upd_mispred = umis;
        end else begin
            upd_pc = 'x; upd_uncond = 'x; upd_taken = 'x;
            upd_target = 'x; upd_mispred = 'x;
        end
        exp_q.push_back(m_lookup(ipc));
        @(negedge clk);
        e = exp_q.pop_front();
        check("pred_hit", {63'd0, pred_hit}, {63'd0, e[33]});
        check("pred_taken", {63'd0, pred_taken}, {63'd0, e[32]});
        check("pred_target", {32'd0, pred_target}, {32'd0, e[31:0]});
        @(posedge clk);
        m_update(uv, upc, unc, ut, utgt, umis, fl);
        #1;
        check("perf_upd", {32'd0, perf_upd}, m_pu);
        check("perf_mis", {32'd0, perf_mis}, m_pm);
    endtask

    task automatic upd(input logic [AW-1:0] pc, input bit unc, input bit ut,
                       input logic [AW-1:0] tgt);
        cycle(pc, 1'b1, pc, unc, ut, tgt, 1'b0, 1'b0);
    endtask

    // combinational probe against literal expectations, no clock advance
    task automatic peek(input string tag, input logic [AW-1:0] ipc, input bit eh,
                        input bit et, input logic [AW-1:0] etgt);
        if_pc     = ipc;
        upd_valid = 1'b0;
        bpu_flush = 1'b0;
        #1;
        check({tag, "_hit"}, {63'd0, pred_hit}, {63'd0, eh});
        check({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, et});
        check({tag, "_target"}, {32'd0, pred_target}, {32'd0, etgt});
    endtask

    initial begin
        logic [AW-1:0] rpc, rupc, rtgt;
        rst_n = 1'b0;
        if_pc = 32'h100; upd_valid = 1'b0; bpu_flush = 1'b0;
        upd_pc = '0; upd_uncond = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_mispred = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        peek("t1", 32'h100, 0, 0, 32'h104);
        check("t1_perf_upd", {32'd0, perf_upd}, 64'd0);
        check("t1_perf_mis", {32'd0, perf_mis}, 64'd0);

        // allocate weakly taken, then one not-taken drops to counter 1
        upd(32'h100, 0, 1, 32'h80);
        peek("t2a", 32'h100, 1, 1, 32'h80);
        upd(32'h100, 0, 0, 32'h0);
        peek("t2b", 32'h100, 1, 0, 32'h104);

        // aliasing tag replaces the entry
        peek("t3a", 32'h200, 0, 0, 32'h204);
        upd(32'h200, 0, 1, 32'h40);
        peek("t3b", 32'h100, 0, 0, 32'h104);
        peek("t3c", 32'h200, 1, 1, 32'h40);

        // saturation and unconditional allocation
        repeat (5) upd(32'h10, 0, 1, 32'h500);
        upd(32'h10, 0, 0, 32'h0);
        peek("t4a", 32'h10, 1, 1, 32'h500);
        upd(32'h10, 0, 0, 32'h0);
        peek("t4b", 32'h10, 1, 0, 32'h14);
        upd(32'h20, 1, 1, 32'h400);
        peek("t4c", 32'h20, 1, 1, 32'h400);
        upd(32'h20, 0, 0, 32'h0);
        peek("t4d", 32'h20, 1, 1, 32'h400);

        // same-cycle lookup and update: old contents visible this cycle
        cycle(32'h30, 1, 32'h30, 0, 1, 32'h90, 1, 0);
        peek("t5", 32'h30, 1, 1, 32'h90);

        // target wraps modulo 2**32
        peek("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

        // flush with a simultaneous update: table cleared, perf still counts
        cycle(32'h30, 1, 32'h40, 0, 1, 32'h44, 1, 1);
        peek("t6a", 32'h30, 0, 0, 32'h34);
        peek("t6b", 32'h40, 0, 0, 32'h44);
        peek("t6c", 32'h20, 0, 0, 32'h24);

        // asynchronous reset in the middle of an update
        upd(32'h10, 0, 1, 32'h500);
        if_pc = 32'h10; upd_valid = 1'b1; upd_pc = 32'h10; upd_uncond = 1'b1;
        upd_taken = 1'b1; upd_target = 32'h700; upd_mispred = 1'b1; bpu_flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_hit", {63'd0, pred_hit}, 64'd0);
        check("rst_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_target", {32'd0, pred_target}, 64'h14);
        check("rst_perf_upd", {32'd0, perf_upd}, 64'd0);
        check("rst_perf_mis", {32'd0, perf_mis}, 64'd0);
        m_reset();
        @(posedge clk);
        upd_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        peek("rst_after", 32'h10, 0, 0, 32'h14);

        // random traffic over a small address pool so entries collide
        for (int n = 0; n < 600; n++) begin
            rpc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                   | 32'($urandom_range(0, 3));
            rupc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                   | 32'($urandom_range(0, 3));
            rtgt = $urandom;
            cycle(rpc, $urandom_range(0, 2) != 0, rupc, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, rtgt, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
